// File: rtl/k10_clint_if.sv
// AXI4-Lite bundle between the K10 peripheral initiator and the CLINT responder.
// Signal names keep their responder-side direction prefix so both ends read the same.
interface k10_clint_if;
   logic [31:0] i_awaddr;
   logic [2:0]  i_awprot;
   logic        i_awvalid;
   logic        o_awready;
   logic [31:0] i_wdata;
   logic [3:0]  i_wstrb;
   logic        i_wvalid;
   logic        o_wready;
   logic [1:0]  o_bresp;
   logic        o_bvalid;
   logic        i_bready;
   logic [31:0] i_araddr;
   logic [2:0]  i_arprot;
   logic        i_arvalid;
   logic        o_arready;
   logic [31:0] o_rdata;
   logic [1:0]  o_rresp;
   logic        o_rvalid;
   logic        i_rready;

   modport slave (
      input  i_awaddr, i_awprot, i_awvalid, output o_awready,
      input  i_wdata, i_wstrb, i_wvalid,    output o_wready,
      output o_bresp, o_bvalid,             input  i_bready,
      input  i_araddr, i_arprot, i_arvalid, output o_arready,
      output o_rdata, o_rresp, o_rvalid,    input  i_rready
   );

   modport master (
      output i_awaddr, i_awprot, i_awvalid, input  o_awready,
      output i_wdata, i_wstrb, i_wvalid,    input  o_wready,
      input  o_bresp, o_bvalid,             output i_bready,
      output i_araddr, i_arprot, i_arvalid, input  o_arready,
      input  o_rdata, o_rresp, o_rvalid,    output i_rready
   );
endinterface

// File: rtl/k10_clint.sv
// K10 CLINT: AXI4-Lite responder holding mtime, mtimecmp and msip, driving the
// core's timer and software interrupt lines.
module k10_clint #(
   parameter int TICK_DIV   = 1,
   parameter int ADDR_LSB_W = 5
) (
   input  logic        i_clk,
   input  logic        i_rst,
   k10_clint_if.slave  bus,
   output logic [63:0] o_mtime,
   output logic        o_timer_irq,
   output logic        o_sw_irq
);
   localparam int         PSC_W       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [2:0] {
      REG_MSIP, REG_CMP_LO, REG_CMP_HI, REG_MT_LO, REG_MT_HI, REG_NONE
   } reg_sel_e;

   function automatic reg_sel_e decode(input logic [ADDR_LSB_W-1:0] off);
      reg_sel_e sel;
      sel = REG_NONE;
      if (off[1:0] == 2'b00) begin
         case (off)
            ADDR_LSB_W'('h00): sel = REG_MSIP;
            ADDR_LSB_W'('h08): sel = REG_CMP_LO;
            ADDR_LSB_W'('h0C): sel = REG_CMP_HI;
            ADDR_LSB_W'('h10): sel = REG_MT_LO;
            ADDR_LSB_W'('h14): sel = REG_MT_HI;
            default:           sel = REG_NONE;
         endcase
      end
      return sel;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                         input logic [3:0] strb);
      logic [31:0] v;
      for (int b = 0; b < 4; b++) v[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
      return v;
   endfunction

   // register file
   logic [63:0]      r_mtime;
   logic [63:0]      r_mtimecmp;
   logic             r_msip;
   logic [PSC_W-1:0] r_psc;
   logic             r_timer_irq;

   // write channel state
   logic                  r_aw_held;
   logic                  r_w_held;
   logic [ADDR_LSB_W-1:0] r_awaddr;
   logic [31:0]           r_wdata;
   logic [3:0]            r_wstrb;
   logic                  r_bvalid;
   logic [1:0]            r_bresp;

   // read channel state
   logic        r_rvalid;
   logic [1:0]  r_rresp;
   logic [31:0] r_rdata;

   logic                  w_awready, w_wready, w_arready;
   logic                  w_aw_hs, w_w_hs, w_ar_hs, w_commit;
   logic [ADDR_LSB_W-1:0] w_wr_addr;
   logic [31:0]           w_wr_data;
   logic [3:0]            w_wr_strb;
   reg_sel_e              w_wr_sel, w_rd_sel;
   logic [31:0]           w_rd_val;
   logic                  w_tick;
   logic                  w_we_msip, w_we_cmp_lo, w_we_cmp_hi, w_we_mt_lo, w_we_mt_hi;
   logic                  w_unused;

   // Base selection happens upstream; protection bits carry no meaning here.
   assign w_unused = ^{bus.i_awprot, bus.i_arprot,
                       bus.i_awaddr[31:ADDR_LSB_W], bus.i_araddr[31:ADDR_LSB_W]};

   assign w_awready = !r_aw_held && !r_bvalid;
   assign w_wready  = !r_w_held && !r_bvalid;
   assign w_arready = !r_rvalid;
   assign w_aw_hs   = bus.i_awvalid && w_awready;
   assign w_w_hs    = bus.i_wvalid && w_wready;
   assign w_ar_hs   = bus.i_arvalid && w_arready;

   // A commit needs one address and one data beat, each either parked or arriving now.
   assign w_commit  = (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);
   assign w_wr_addr = r_aw_held ? r_awaddr : bus.i_awaddr[ADDR_LSB_W-1:0];
   assign w_wr_data = r_w_held ? r_wdata : bus.i_wdata;
   assign w_wr_strb = r_w_held ? r_wstrb : bus.i_wstrb;
   assign w_wr_sel  = decode(w_wr_addr);
   assign w_rd_sel  = decode(bus.i_araddr[ADDR_LSB_W-1:0]);

   assign w_we_msip   = w_commit && (w_wr_sel == REG_MSIP);
   assign w_we_cmp_lo = w_commit && (w_wr_sel == REG_CMP_LO);
   assign w_we_cmp_hi = w_commit && (w_wr_sel == REG_CMP_HI);
   assign w_we_mt_lo  = w_commit && (w_wr_sel == REG_MT_LO);
   assign w_we_mt_hi  = w_commit && (w_wr_sel == REG_MT_HI);

   assign w_tick = (r_psc == PSC_W'(TICK_DIV - 1));

   always_comb begin
      w_rd_val = '0;
      case (w_rd_sel)
         REG_MSIP:   w_rd_val = {31'd0, r_msip};
         REG_CMP_LO: w_rd_val = r_mtimecmp[31:0];
         REG_CMP_HI: w_rd_val = r_mtimecmp[63:32];
         REG_MT_LO:  w_rd_val = r_mtime[31:0];
         REG_MT_HI:  w_rd_val = r_mtime[63:32];
         default:    w_rd_val = '0;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_aw_held <= 1'b0;
         r_w_held  <= 1'b0;
         r_awaddr  <= '0;
         r_wdata   <= '0;
         r_wstrb   <= '0;
         r_bvalid  <= 1'b0;
         r_bresp   <= RESP_OKAY;
      end else if (w_commit) begin
         r_aw_held <= 1'b0;
         r_w_held  <= 1'b0;
         r_bvalid  <= 1'b1;
         r_bresp   <= (w_wr_sel == REG_NONE) ? RESP_SLVERR : RESP_OKAY;
      end else begin
         if (w_aw_hs) begin
            r_aw_held <= 1'b1;
            r_awaddr  <= bus.i_awaddr[ADDR_LSB_W-1:0];
         end
         if (w_w_hs) begin
            r_w_held <= 1'b1;
            r_wdata  <= bus.i_wdata;
            r_wstrb  <= bus.i_wstrb;
         end
         if (r_bvalid && bus.i_bready) r_bvalid <= 1'b0;
      end
   end

   // Read data is captured from pre-update register values, so a same-cycle
   // write to the same register is not visible to this read.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rvalid <= 1'b0;
         r_rdata  <= '0;
         r_rresp  <= RESP_OKAY;
      end else if (w_ar_hs) begin
         r_rvalid <= 1'b1;
         r_rdata  <= w_rd_val;
         r_rresp  <= (w_rd_sel == REG_NONE) ? RESP_SLVERR : RESP_OKAY;
      end else if (r_rvalid && bus.i_rready) begin
         r_rvalid <= 1'b0;
      end
   end

   // A software write to either mtime half suppresses that cycle's increment;
   // the prescaler keeps its phase regardless.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_psc   <= '0;
         r_mtime <= '0;
      end else begin
         r_psc <= w_tick ? '0 : r_psc + 1'b1;
         if (w_we_mt_lo)      r_mtime[31:0]  <= merge(r_mtime[31:0], w_wr_data, w_wr_strb);
         else if (w_we_mt_hi) r_mtime[63:32] <= merge(r_mtime[63:32], w_wr_data, w_wr_strb);
         else if (w_tick)     r_mtime        <= r_mtime + 64'd1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_mtimecmp  <= '1;
         r_msip      <= 1'b0;
         r_timer_irq <= 1'b0;
      end else begin
         if (w_we_cmp_lo) r_mtimecmp[31:0]  <= merge(r_mtimecmp[31:0], w_wr_data, w_wr_strb);
         if (w_we_cmp_hi) r_mtimecmp[63:32] <= merge(r_mtimecmp[63:32], w_wr_data, w_wr_strb);
         if (w_we_msip && w_wr_strb[0]) r_msip <= w_wr_data[0];
         r_timer_irq <= (r_mtime >= r_mtimecmp);
      end
   end

   assign bus.o_awready = w_awready;
   assign bus.o_wready  = w_wready;
   assign bus.o_bvalid  = r_bvalid;
   assign bus.o_bresp   = r_bresp;
   assign bus.o_arready = w_arready;
   assign bus.o_rvalid  = r_rvalid;
   assign bus.o_rdata   = r_rdata;
   assign bus.o_rresp   = r_rresp;

   assign o_mtime     = r_mtime;
   assign o_timer_irq = r_timer_irq;
   assign o_sw_irq    = r_msip;
endmodule

// File: tb/tb_k10_clint.sv
// Bench for k10_clint: two instances (TICK_DIV 1 and 3) share one stimulus bus and are
// checked every cycle against a transaction-level model, plus directed literal checks.
module tb_k10_clint;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
   logic [3:0]  wstrb = '0;
   logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0, bready = 1'b1, rready = 1'b1;

   k10_clint_if bus_a ();
   k10_clint_if bus_b ();

   assign bus_a.i_awaddr = awaddr;  assign bus_a.i_awprot = 3'd0; assign bus_a.i_awvalid = awvalid;
   assign bus_a.i_wdata  = wdata;   assign bus_a.i_wstrb  = wstrb; assign bus_a.i_wvalid  = wvalid;
   assign bus_a.i_bready = bready;  assign bus_a.i_araddr = araddr; assign bus_a.i_arprot = 3'd0;
   assign bus_a.i_arvalid = arvalid; assign bus_a.i_rready = rready;
   assign bus_b.i_awaddr = awaddr;  assign bus_b.i_awprot = 3'd0; assign bus_b.i_awvalid = awvalid;
   assign bus_b.i_wdata  = wdata;   assign bus_b.i_wstrb  = wstrb; assign bus_b.i_wvalid  = wvalid;
   assign bus_b.i_bready = bready;  assign bus_b.i_araddr = araddr; assign bus_b.i_arprot = 3'd0;
   assign bus_b.i_arvalid = arvalid; assign bus_b.i_rready = rready;

   logic [63:0] mt_a, mt_b;
   logic        tirq_a, tirq_b, sw_a, sw_b;

   k10_clint #(.TICK_DIV(1), .ADDR_LSB_W(5)) u_dut_a (
      .i_clk(clk), .i_rst(rst), .bus(bus_a),
      .o_mtime(mt_a), .o_timer_irq(tirq_a), .o_sw_irq(sw_a));
   k10_clint #(.TICK_DIV(3), .ADDR_LSB_W(5)) u_dut_b (
      .i_clk(clk), .i_rst(rst), .bus(bus_b),
      .o_mtime(mt_b), .o_timer_irq(tirq_b), .o_sw_irq(sw_b));

   int n_chk = 0, n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         if (n_err <= 50) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct packed {
      logic [1:0][63:0] mt;
      logic [1:0][63:0] cmp;
      logic [1:0][31:0] rd;
      logic [1:0][1:0]  psc;
      logic [1:0]       msip;
      logic [1:0]       irq;
      logic             awh, wh, bv, rv;
      logic [31:0]      ha, hd;
      logic [3:0]       hs;
      logic [1:0]       br, rr;
   } mdl_t;

   mdl_t m;
   logic m_live = 1'b0;

   function automatic int td(input int k);
      return (k == 0) ? 1 : 3;
   endfunction

   // 0 msip, 1 cmp lo, 2 cmp hi, 3 mtime lo, 4 mtime hi, -1 invalid
   function automatic int reg_idx(input logic [31:0] a);
      int off;
      off = int'(a % 32);
      if (off % 4 != 0) return -1;
      case (off)
         0: return 0;  8: return 1;  12: return 2;  16: return 3;  20: return 4;
         default: return -1;
      endcase
   endfunction

   function automatic logic [31:0] reg_val(input mdl_t s, input int k, input int idx);
      case (idx)
         0: return {31'd0, s.msip[k]};
         1: return s.cmp[k][31:0];
         2: return s.cmp[k][63:32];
         3: return s.mt[k][31:0];
         4: return s.mt[k][63:32];
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] bytes_in(input logic [31:0] v, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] r;
      r = v;
      for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   always @(posedge clk) begin
      mdl_t n;
      logic aw_hs, w_hs, ar_hs, commit, tick;
      logic [31:0] a, d;
      logic [3:0] s;
      int wi, ri;
      n = m;
      if (rst) begin
         n = '0;
         n.cmp = {2{64'hFFFF_FFFF_FFFF_FFFF}};
         m_live <= 1'b1;
      end else begin
         aw_hs  = awvalid && !m.awh && !m.bv;
         w_hs   = wvalid && !m.wh && !m.bv;
         ar_hs  = arvalid && !m.rv;
         commit = (m.awh || aw_hs) && (m.wh || w_hs);
         a  = m.awh ? m.ha : awaddr;
         d  = m.wh ? m.hd : wdata;
         s  = m.wh ? m.hs : wstrb;
         wi = commit ? reg_idx(a) : -2;
         ri = reg_idx(araddr);
         for (int k = 0; k < 2; k++) begin
            n.irq[k] = (m.mt[k] >= m.cmp[k]);
            if (ar_hs) n.rd[k] = reg_val(m, k, ri);
            tick = (int'(m.psc[k]) == td(k) - 1);
            n.psc[k] = tick ? 2'd0 : m.psc[k] + 2'd1;
            if (wi == 3)      n.mt[k][31:0]  = bytes_in(m.mt[k][31:0], d, s);
            else if (wi == 4) n.mt[k][63:32] = bytes_in(m.mt[k][63:32], d, s);
            else if (tick)    n.mt[k]        = m.mt[k] + 64'd1;
            if (wi == 1) n.cmp[k][31:0]  = bytes_in(m.cmp[k][31:0], d, s);
            if (wi == 2) n.cmp[k][63:32] = bytes_in(m.cmp[k][63:32], d, s);
            if (wi == 0 && s[0]) n.msip[k] = d[0];
         end
         if (ar_hs) begin
            n.rv = 1'b1;
            n.rr = (ri < 0) ? 2'b10 : 2'b00;
         end else if (m.rv && rready) n.rv = 1'b0;
         if (commit) begin
            n.bv = 1'b1; n.br = (wi < 0) ? 2'b10 : 2'b00; n.awh = 1'b0; n.wh = 1'b0;
         end else begin
            if (aw_hs) begin n.awh = 1'b1; n.ha = awaddr; end
            if (w_hs)  begin n.wh = 1'b1; n.hd = wdata; n.hs = wstrb; end
            if (m.bv && bready) n.bv = 1'b0;
         end
      end
      m <= n;
   end

   task automatic cmp_dut(input int k, input string nm, input logic awr, input logic wr, input logic arr,
                          input logic bv, input logic [1:0] br, input logic rv, input logic [31:0] rd,
                          input logic [1:0] rr, input logic [63:0] mt, input logic ti, input logic si);
      chk({nm, ".awready"}, awr, !m.awh && !m.bv);
      chk({nm, ".wready"},  wr,  !m.wh && !m.bv);
      chk({nm, ".arready"}, arr, !m.rv);
      chk({nm, ".bvalid"},  bv,  m.bv);
      chk({nm, ".bresp"},   br,  m.br);
      chk({nm, ".rvalid"},  rv,  m.rv);
      chk({nm, ".rdata"},   rd,  m.rd[k]);
      chk({nm, ".rresp"},   rr,  m.rr);
      chk({nm, ".mtime"},   mt,  m.mt[k]);
      chk({nm, ".timer_irq"}, ti, m.irq[k]);
      chk({nm, ".sw_irq"},  si,  m.msip[k]);
   endtask

   always @(negedge clk) begin
      if (m_live) begin
         cmp_dut(0, "A", bus_a.o_awready, bus_a.o_wready, bus_a.o_arready, bus_a.o_bvalid, bus_a.o_bresp,
                 bus_a.o_rvalid, bus_a.o_rdata, bus_a.o_rresp, mt_a, tirq_a, sw_a);
         cmp_dut(1, "B", bus_b.o_awready, bus_b.o_wready, bus_b.o_arready, bus_b.o_bvalid, bus_b.o_bresp,
                 bus_b.o_rvalid, bus_b.o_rdata, bus_b.o_rresp, mt_b, tirq_b, sw_b);
      end
   end

   // ---------------- stimulus (all tasks start and end at posedge+1) ----------------
   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            output logic [1:0] resp);
      logic aw_ok, w_ok;
      int t;
      awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
      t = 0;
      while ((awvalid || wvalid) && t < 20) begin
         @(negedge clk); aw_ok = bus_a.o_awready; w_ok = bus_a.o_wready;
         step();
         if (aw_ok) awvalid = 1'b0;
         if (w_ok)  wvalid = 1'b0;
         t++;
      end
      chk("wr_addr_data_timeout", (awvalid || wvalid), 1'b0);
      awvalid = 1'b0; wvalid = 1'b0;
      resp = 2'bxx;
      t = 0;
      while (t < 20) begin
         @(negedge clk);
         if (bus_a.o_bvalid) begin resp = bus_a.o_bresp; step(); break; end
         t++;
      end
      chk("wr_resp_timeout", t >= 20, 1'b0);
   endtask

   task automatic axi_read(input logic [31:0] addr, output logic [31:0] da, output logic [31:0] db,
                           output logic [1:0] resp);
      logic ar_ok;
      int t;
      araddr = addr; arvalid = 1'b1; rready = 1'b1;
      t = 0;
      while (arvalid && t < 20) begin
         @(negedge clk); ar_ok = bus_a.o_arready;
         step();
         if (ar_ok) arvalid = 1'b0;
         t++;
      end
      chk("rd_addr_timeout", arvalid, 1'b0);
      arvalid = 1'b0;
      da = 'x; db = 'x; resp = 2'bxx;
      t = 0;
      while (t < 20) begin
         @(negedge clk);
         if (bus_a.o_rvalid) begin
            da = bus_a.o_rdata; db = bus_b.o_rdata; resp = bus_a.o_rresp; step(); break;
         end
         t++;
      end
      chk("rd_data_timeout", t >= 20, 1'b0);
   endtask

   // Launch a single-beat write whose commit edge is a tick edge of the TICK_DIV=3 instance.
   task automatic aligned_write(input logic [31:0] addr, input logic [31:0] data);
      int t;
      t = 0;
      while (m.psc[1] != 2'd2 && t < 10) begin step(); t++; end
      chk("align_timeout", t >= 10, 1'b0);
      awaddr = addr; wdata = data; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      @(negedge clk);
      chk("align_ready", {bus_a.o_awready, bus_a.o_wready}, 2'b11);
      step();
      awvalid = 1'b0; wvalid = 1'b0;
   endtask

   logic [31:0] rda, rdb;
   logic [1:0]  rsp;

   initial begin
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // reset state and free-running mtime
      @(negedge clk);
      chk("rst_mtime_a0", mt_a, 64'd0);
      chk("rst_timer_irq", tirq_a, 1'b0);
      chk("rst_sw_irq", sw_a, 1'b0);
      chk("rst_ready", {bus_a.o_awready, bus_a.o_wready, bus_a.o_arready}, 3'b111);
      chk("rst_valid", {bus_a.o_bvalid, bus_a.o_rvalid}, 2'b00);
      @(negedge clk); chk("count_mtime_a1", mt_a, 64'd1);
      @(negedge clk); chk("count_mtime_a2", mt_a, 64'd2);
      chk("count_mtime_b_div3", mt_b, 64'd0);
      step();

      axi_read(32'h08, rda, rdb, rsp);
      chk("rst_cmp_lo", rda, 32'hFFFF_FFFF); chk("rst_cmp_lo_resp", rsp, 2'b00);
      axi_read(32'h0C, rda, rdb, rsp);
      chk("rst_cmp_hi", rda, 32'hFFFF_FFFF); chk("rst_cmp_hi_resp", rsp, 2'b00);
      axi_read(32'h00, rda, rdb, rsp);
      chk("rst_msip", rda, 32'd0); chk("rst_msip_resp", rsp, 2'b00);

      // timer compare at 40
      axi_write(32'h0C, 32'd0, 4'hF, rsp);  chk("cmp_hi_wr_resp", rsp, 2'b00);
      axi_write(32'h08, 32'd40, 4'hF, rsp); chk("cmp_lo_wr_resp", rsp, 2'b00);
      begin
         int t;
         t = 0;
         while (t < 100) begin
            @(negedge clk);
            if (mt_a == 64'd40) break;
            t++;
         end
         chk("wait_mtime40_timeout", t >= 100, 1'b0);
      end
      chk("irq_low_at_40", tirq_a, 1'b0);
      @(negedge clk);
      chk("irq_high_after_40", tirq_a, 1'b1);
      chk("mtime_41", mt_a, 64'd41);
      step();
      axi_write(32'h0C, 32'd1, 4'hF, rsp);
      chk("irq_drop_after_cmp_hi", tirq_a, 1'b0);

      // decoupled AW/W with response backpressure
      for (int t = 0; t <= 22; t++) begin
         awaddr = 32'h00; wdata = 32'd1; wstrb = 4'hF;
         awvalid = (t == 10); wvalid = (t == 14); bready = (t >= 20);
         @(negedge clk);
         chk($sformatf("dec_awready_c%0d", t), bus_a.o_awready, (t <= 10 || t >= 21));
         chk($sformatf("dec_wready_c%0d", t),  bus_a.o_wready,  (t <= 14 || t >= 21));
         chk($sformatf("dec_bvalid_c%0d", t),  bus_a.o_bvalid,  (t >= 15 && t <= 20));
         chk($sformatf("dec_sw_irq_c%0d", t),  sw_a, (t >= 15));
         if (t >= 15 && t <= 20) chk($sformatf("dec_bresp_c%0d", t), bus_a.o_bresp, 2'b00);
         step();
      end
      awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;

      // partial strobes
      axi_write(32'h08, 32'hFFFF_FFFF, 4'hF, rsp);
      axi_write(32'h08, 32'hAABB_CCDD, 4'b0101, rsp);
      axi_read(32'h08, rda, rdb, rsp);
      chk("strobe_merge", rda, 32'hFFBB_FFDD);

      // invalid accesses, strobe-less write, upper address bits ignored
      axi_read(32'h04, rda, rdb, rsp);
      chk("rd_0x04_resp", rsp, 2'b10); chk("rd_0x04_data", rda, 32'd0);
      axi_write(32'h1C, 32'h1234_5678, 4'hF, rsp);
      chk("wr_0x1C_resp", rsp, 2'b10);
      axi_read(32'h08, rda, rdb, rsp);
      chk("wr_0x1C_no_effect", rda, 32'hFFBB_FFDD);
      axi_read(32'h09, rda, rdb, rsp);
      chk("rd_0x09_resp", rsp, 2'b10); chk("rd_0x09_data", rda, 32'd0);
      axi_write(32'h00, 32'd0, 4'h0, rsp);
      chk("wstrb0_resp", rsp, 2'b00); chk("wstrb0_msip_kept", sw_a, 1'b1);
      axi_read(32'h1000_0008, rda, rdb, rsp);
      chk("upper_addr_ignored", rda, 32'hFFBB_FFDD);

      // write/tick collision and 64-bit wrap
      axi_write(32'h14, 32'hFFFF_FFFF, 4'hF, rsp);
      aligned_write(32'h10, 32'hFFFF_FFFF);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk($sformatf("wrap_b_%0d", i), mt_b, (i < 3) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'd0);
         if (i < 2) chk($sformatf("wrap_a_%0d", i), mt_a, (i == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'd0);
         step();
      end

      // carry from low into high word
      axi_write(32'h14, 32'd0, 4'hF, rsp);
      aligned_write(32'h10, 32'hFFFF_FFFF);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk($sformatf("carry_b_%0d", i), mt_b, (i < 3) ? 64'h0000_0000_FFFF_FFFF : 64'h0000_0001_0000_0000);
         if (i < 2) chk($sformatf("carry_a_%0d", i), mt_a, (i == 0) ? 64'h0000_0000_FFFF_FFFF : 64'h0000_0001_0000_0000);
         step();
      end

      // reset with an address parked: no response may follow a lone data beat
      awaddr = 32'h00; awvalid = 1'b1;
      step();
      awvalid = 1'b0; rst = 1'b1;
      step();
      rst = 1'b0; wdata = 32'd1; wstrb = 4'hF; wvalid = 1'b1;
      step();
      wvalid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("abort_bvalid_%0d", i), bus_a.o_bvalid, 1'b0);
         chk($sformatf("abort_sw_irq_%0d", i), sw_a, 1'b0);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
